spm_copy_engine: RTL

Single-port initiator for the scratchpad memory (SPM): it drives one port of the dual-port SPM RAM as a master, performing block copy (SPM→SPM) or block fill under a start/done handshake, so the CPU-side port stays free for the pipeline. It sits beside the SPM and owns port B exclusively, handling the RAM's one-cycle registered read latency internally.

---
 rtl/spm_copy_engine_if.sv | 61 ++++++
 rtl/spm_copy_engine.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/spm_copy_engine_if.sv
// ----------------------------------------------------------------------------
// spm_copy_engine_if.sv
// Interface bundles for the SPM copy/fill engine.
//
//   spm_ctrl_if : request/completion handshake between a controller and the
//                 engine.
//                 master = controller (drives the request fields and abort)
//                 slave  = engine     (drives busy/done/aborted)
//     start, mode, src_addr, dst_addr, len, fill_data, abort  : request side
//     busy, done, aborted                                      : status side
//
//   spm_port_if : one port of the SPM RAM (registered read, 1-cycle latency).
//                 master = engine (drives address, write enable, write data)
//                 slave  = RAM    (drives read data)
// ----------------------------------------------------------------------------
interface spm_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 13
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] fill_data;
  logic              abort;
  logic              busy;
  logic              done;
  logic              aborted;

  modport master (
    output start, mode, src_addr, dst_addr, len, fill_data, abort,
    input  busy, done, aborted
  );

  modport slave (
    input  start, mode, src_addr, dst_addr, len, fill_data, abort,
    output busy, done, aborted
  );
endinterface

interface spm_port_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] spm_addr;
  logic              spm_we;
  logic [DATA_W-1:0] spm_wr_data;
  logic [DATA_W-1:0] spm_rd_data;

  modport master (
    output spm_addr, spm_we, spm_wr_data,
    input  spm_rd_data
  );

  modport slave (
    input  spm_addr, spm_we, spm_wr_data,
    output spm_rd_data
  );
endinterface

// File: rtl/spm_copy_engine.sv
// ----------------------------------------------------------------------------
// spm_copy_engine.sv
// Block copy (SPM->SPM) / block fill engine driving one SPM RAM port.
//
// Ports:
//   clk   : clock, all state changes on posedge
//   reset : asynchronous active-high reset
//   ctrl  : spm_ctrl_if.slave  - start/mode/src_addr/dst_addr/len/fill_data/
//           abort in; busy/done/aborted out
//   port  : spm_port_if.master - spm_addr/spm_we/spm_wr_data out,
//           spm_rd_data in (valid the cycle after the address)
//
// Copy alternates READ and WRITE cycles (2 cycles/word) so the registered
// read data is available while the destination word is presented. Fill stays
// in WRITE (1 cycle/word). Port drive is purely combinational from the state
// and pointer registers, so an asynchronous reset drops spm_we at once.
// ----------------------------------------------------------------------------
module spm_copy_engine #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 13
) (
  input  logic        clk,
  input  logic        reset,
  spm_ctrl_if.slave   ctrl,
  spm_port_if.master  port
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] src_ptr_reg, src_ptr_next;
  logic [ADDR_W-1:0] dst_ptr_reg, dst_ptr_next;
  logic [LEN_W-1:0]  remaining_reg, remaining_next;
  logic              mode_reg, mode_next;
  logic [DATA_W-1:0] fill_reg, fill_next;
  logic              aborted_reg, aborted_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      src_ptr_reg   <= '0;
      dst_ptr_reg   <= '0;
      remaining_reg <= '0;
      mode_reg      <= 1'b0;
      fill_reg      <= '0;
      aborted_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      src_ptr_reg   <= src_ptr_next;
      dst_ptr_reg   <= dst_ptr_next;
      remaining_reg <= remaining_next;
      mode_reg      <= mode_next;
      fill_reg      <= fill_next;
      aborted_reg   <= aborted_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    src_ptr_next     = src_ptr_reg;
    dst_ptr_next     = dst_ptr_reg;
    remaining_next   = remaining_reg;
    mode_next        = mode_reg;
    fill_next        = fill_reg;
    aborted_next     = aborted_reg;
    port.spm_addr    = '0;
    port.spm_we      = 1'b0;
    port.spm_wr_data = '0;

    case (state_reg)
      ST_IDLE: begin
        if (ctrl.start) begin
          src_ptr_next   = ctrl.src_addr;
          dst_ptr_next   = ctrl.dst_addr;
          remaining_next = ctrl.len;
          mode_next      = ctrl.mode;
          fill_next      = ctrl.fill_data;
          aborted_next   = 1'b0;
          if (ctrl.len == '0) begin
            state_next = ST_DONE;
          end else if (ctrl.mode) begin
            state_next = ST_WRITE;
          end else begin
            state_next = ST_READ;
          end
        end
      end

      ST_READ: begin
        port.spm_addr = src_ptr_reg;
        if (ctrl.abort) begin
          aborted_next = 1'b1;
          state_next   = ST_DONE;
        end else begin
          // Pointer wraps naturally at 2^ADDR_W.
          src_ptr_next = src_ptr_reg + 1'b1;
          state_next   = ST_WRITE;
        end
      end

      ST_WRITE: begin
        port.spm_addr    = dst_ptr_reg;
        port.spm_we      = 1'b1;
        // In copy mode the RAM output holds the word addressed in READ.
        port.spm_wr_data = mode_reg ? fill_reg : port.spm_rd_data;
        if (ctrl.abort) begin
          // The write shown this cycle still commits at this edge.
          aborted_next = 1'b1;
          state_next   = ST_DONE;
        end else begin
          dst_ptr_next   = dst_ptr_reg + 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == LEN_W'(1)) begin
            state_next = ST_DONE;
          end else if (mode_reg) begin
            state_next = ST_WRITE;
          end else begin
            state_next = ST_READ;
          end
        end
      end

      ST_DONE: begin
        aborted_next = 1'b0;
        state_next   = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign ctrl.busy    = (state_reg == ST_READ) || (state_reg == ST_WRITE);
  assign ctrl.done    = (state_reg == ST_DONE);
  assign ctrl.aborted = (state_reg == ST_DONE) && aborted_reg;

endmodule
